// File: rtl/mem_sdp_pkg.sv
// Shared types and constants for the mem_sdp simple dual-port RAM.
// FSM state encoding and legal read-latency range.
package mem_sdp_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_sdp_rdpipe.sv
// Read-data delay line with valid tracking for mem_sdp.
// Each stage captures data only on valid, so output holds when idle.
module mem_sdp_rdpipe
  import mem_sdp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("mem_sdp_rdpipe: RD_LAT must be 1 or 2");
  end

  logic [RD_LAT-1:0] vld;
  logic [DATA_W-1:0] dat [RD_LAT];

  // shift valid every cycle, advance data only behind a valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/mem_sdp.sv
// Simple dual-port RAM with power-on clear and registered read port.
// MEM_SDP_PARITY_EN adds a stored even-parity bit, par_inj and par_err.
module mem_sdp
  import mem_sdp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addrw,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addrr,
`ifdef MEM_SDP_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_SDP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nx;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [MEM_W-1:0]  mem_wd;
  logic [MEM_W-1:0]  wword;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  pipe_out;
  logic              rd_acc;

  logic [MEM_W-1:0]  mem [DEPTH];

`ifdef MEM_SDP_PARITY_EN
  assign wword = {(^wdata) ^ par_inj, wdata};
`else
  assign wword = wdata;
`endif

  // FSM state and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // next state and array port steering
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    mem_we     = 1'b0;
    mem_wa     = addrw;
    mem_wd     = wword;
    rd_acc     = 1'b0;
    unique case (state)
      INIT: begin
        mem_we     = 1'b1;
        mem_wa     = clr_cnt;
        mem_wd     = '0;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (&clr_cnt) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        mem_we = wr_en;
        rd_acc = rd_en;
      end
      default: state_nx = INIT;
    endcase
    if (rst) begin
      mem_we = 1'b0;
      rd_acc = 1'b0;
    end
  end

  // storage array, never reset directly
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // same-address write forwards new data in write-first mode
  always_comb begin
    rd_word = mem[addrr];
    if ((BYPASS != 0) && wr_en && (addrw == addrr)) begin
      rd_word = wword;
    end
  end

  mem_sdp_rdpipe #(
    .DATA_W (MEM_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (pipe_out)
  );

  assign rdata     = pipe_out[DATA_W-1:0];
  assign init_done = (state == RUN);

`ifdef MEM_SDP_PARITY_EN
  assign par_err = rvalid & (^pipe_out);
`endif

endmodule

// File: tb/tb_mem_sdp.sv
// Directed bench for mem_sdp: a write-first RD_LAT=1 instance and a
// read-first RD_LAT=2 instance driven by the same stimulus.
module tb_mem_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  addrw;
  logic [15:0] wdata;
  logic        rd_en;
  logic [3:0]  addrr;
  logic [15:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic        id1, id2;
`ifdef MEM_SDP_PARITY_EN
  logic        par_inj;
  logic        pe1, pe2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sdp #(
    .DATA_W (16),
    .ADDR_W (4),
    .RD_LAT (1),
    .BYPASS (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .addrw     (addrw),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .addrr     (addrr),
`ifdef MEM_SDP_PARITY_EN
    .par_inj   (par_inj),
    .par_err   (pe1),
`endif
    .rdata     (rdata1),
    .rvalid    (rvalid1),
    .init_done (id1)
  );

  mem_sdp #(
    .DATA_W (16),
    .ADDR_W (4),
    .RD_LAT (2),
    .BYPASS (0)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .addrw     (addrw),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .addrr     (addrr),
`ifdef MEM_SDP_PARITY_EN
    .par_inj   (par_inj),
    .par_err   (pe2),
`endif
    .rdata     (rdata2),
    .rvalid    (rvalid2),
    .init_done (id2)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string tag, logic v, logic [15:0] d);
    check({tag, "_rv1"}, 32'(rvalid1), 32'(v));
    check({tag, "_rd1"}, 32'(rdata1), 32'(d));
  endtask

  task automatic chk2(string tag, logic v, logic [15:0] d);
    check({tag, "_rv2"}, 32'(rvalid2), 32'(v));
    check({tag, "_rd2"}, 32'(rdata2), 32'(d));
  endtask

  function automatic logic [15:0] val(int i);
    return 16'hA000 + 16'(i) * 16'h0111;
  endfunction

  task automatic rd_all_zero(string tag);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      addrr = 4'(i);
      step();
      chk1(tag, 1'b1, 16'h0000);
      if (i == 0) chk2(tag, 1'b0, 16'h0000);
      else        chk2(tag, 1'b1, 16'h0000);
    end
    rd_en = 1'b0;
    step();
    chk1({tag, "_end"}, 1'b0, 16'h0000);
    chk2({tag, "_end"}, 1'b1, 16'h0000);
  endtask

  task automatic init_wait(string tag);
    for (int i = 0; i < 15; i++) begin
      step();
      check({tag, "_rv1"}, 32'(rvalid1), 32'd0);
      check({tag, "_rv2"}, 32'(rvalid2), 32'd0);
    end
    check({tag, "_id1_15"}, 32'(id1), 32'd0);
    check({tag, "_id2_15"}, 32'(id2), 32'd0);
    step();
    check({tag, "_id1_16"}, 32'(id1), 32'd1);
    check({tag, "_id2_16"}, 32'(id2), 32'd1);
    check({tag, "_rv1_16"}, 32'(rvalid1), 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addrw = '0;
    addrr = '0;
    wdata = '0;
`ifdef MEM_SDP_PARITY_EN
    par_inj = 1'b0;
`endif
    step();
    chk1("rst", 1'b0, 16'h0000);
    chk2("rst", 1'b0, 16'h0000);
    check("rst_id1", 32'(id1), 32'd0);
    check("rst_id2", 32'(id2), 32'd0);

    // requests during clear must be ignored
    rst   = 1'b0;
    wr_en = 1'b1;
    addrw = 4'd7;
    wdata = 16'hFFFF;
    rd_en = 1'b1;
    addrr = 4'd7;
    init_wait("init");
    rd_all_zero("clr");

    // write then read next cycle
    wr_en = 1'b1;
    addrw = 4'd3;
    wdata = 16'hBEEF;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    addrr = 4'd3;
    step();
    rd_en = 1'b0;
    chk1("beef", 1'b1, 16'hBEEF);
    chk2("beef_wait", 1'b0, 16'h0000);
    step();
    chk1("beef_hold", 1'b0, 16'hBEEF);
    chk2("beef", 1'b1, 16'hBEEF);

    // same-address collision
    wr_en = 1'b1;
    addrw = 4'd5;
    wdata = 16'h1234;
    rd_en = 1'b1;
    addrr = 4'd5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk1("coll", 1'b1, 16'h1234);
    chk2("coll_wait", 1'b0, 16'hBEEF);
    step();
    chk1("coll_hold", 1'b0, 16'h1234);
    chk2("coll", 1'b1, 16'h0000);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk1("coll_re", 1'b1, 16'h1234);
    chk2("coll_re_wait", 1'b0, 16'h0000);
    step();
    chk2("coll_re", 1'b1, 16'h1234);

    // fill 0..7, then stream reads back-to-back
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      addrw = 4'(i);
      wdata = val(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      addrr = 4'(i);
      step();
      chk1("b2b", 1'b1, val(i));
      if (i == 0) chk2("b2b", 1'b0, 16'h1234);
      else        chk2("b2b", 1'b1, val(i - 1));
    end
    rd_en = 1'b0;
    step();
    chk1("b2b_end", 1'b0, val(7));
    chk2("b2b_end", 1'b1, val(7));
    step();
    chk2("b2b_hold", 1'b0, val(7));

    // reset with reads in flight
    rd_en = 1'b1;
    addrr = 4'd1;
    step();
    addrr = 4'd2;
    step();
    rd_en = 1'b0;
    rst   = 1'b1;
    step();
    chk1("mrst", 1'b0, 16'h0000);
    chk2("mrst", 1'b0, 16'h0000);
    check("mrst_id1", 32'(id1), 32'd0);
    check("mrst_id2", 32'(id2), 32'd0);
    rst = 1'b0;
    init_wait("reinit");
    rd_all_zero("reclr");

`ifdef MEM_SDP_PARITY_EN
    // injected parity error, then clean rewrite
    for (int k = 0; k < 2; k++) begin
      wr_en   = 1'b1;
      addrw   = 4'd9;
      wdata   = 16'h00FF;
      par_inj = (k == 0);
      step();
      wr_en   = 1'b0;
      par_inj = 1'b0;
      rd_en   = 1'b1;
      addrr   = 4'd9;
      step();
      rd_en = 1'b0;
      check("par_rv1", 32'(rvalid1), 32'd1);
      check("par_pe1", 32'(pe1), 32'(k == 0));
      check("par_pe2_wait", 32'(pe2), 32'd0);
      step();
      check("par_pe1_off", 32'(pe1), 32'd0);
      check("par_rv2", 32'(rvalid2), 32'd1);
      check("par_pe2", 32'(pe2), 32'(k == 0));
      check("par_rd2", 32'(rdata2), 32'h00FF);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
